pipe_hazard_ctrl: RTL and testbench

- Central stall/flush/forward controller for the 5-stage RV32IMAC pipeline.
- Drives the `en` and `flush` inputs of the four enable-register pipeline boundaries: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sequences multi-cycle divide occupancy of EX, memory-wait freezes, load-use bubbles and branch-redirect squashes.
- Produces the operand-forwarding selects for EX.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_div_seq.sv | 63 ++++++
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_WAIT = 2'd1,
      DIV_DONE = 2'd2
   } div_st_t;

   // x0 is hard-wired to zero, so it can never be a real producer.
   function automatic logic reg_hit(
      input logic [REG_ADDR_W-1:0] src,
      input logic [REG_ADDR_W-1:0] rd,
      input logic                  we
   );
      return we && (src == rd) && (src != '0);
   endfunction

endpackage

// File: rtl/pipe_div_seq.sv
// Divide occupancy sequencer: holds EX for DIV_CYCLES extra cycles and
// parks in DIV_DONE when the count expires during a memory freeze.
module pipe_div_seq
   import pipe_pkg::*;
#(
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic div_start,
   input  logic freeze,
   output logic dstall,
   output logic div_done_hold,
   output logic div_busy
);

   div_st_t            state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (div_start && !freeze) begin
               state_next = DIV_WAIT;
               cnt_next   = CNT_W'(DIV_CYCLES - 1);
            end
         end
         DIV_WAIT: begin
            if (cnt_reg == '0) begin
               state_next = freeze ? DIV_DONE : IDLE;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         DIV_DONE: begin
            if (!freeze) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign dstall   = ((state_reg == IDLE) && div_start)
                   || ((state_reg == DIV_WAIT) && (cnt_reg != '0));
   // DIV_DONE only holds EX while frozen; its first unfrozen cycle is the release.
   assign div_done_hold = (state_reg == DIV_DONE) && freeze;
   assign div_busy      = (state_reg == DIV_WAIT);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline.
// Define PIPE_FWD_EN to enable MEM/WB operand forwarding; otherwise RAW hazards stall.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_reg_write,
   input  logic                  ex_div_start,
   input  logic                  ex_redirect,
   input  logic                  imem_ready,
   input  logic                  dmem_req,
   input  logic                  dmem_ready,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  id_ex_en,
   output logic                  ex_mem_en,
   output logic                  mem_wb_en,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_flush,
   output logic                  mem_wb_flush,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic                  div_busy
);

   logic                  freeze;
   logic                  dstall;
   logic                  div_done_hold;
   logic                  lu;
   logic                  raw;
   logic [REG_ADDR_W-1:0] src [2];
   logic [1:0]            src_use;
   logic [1:0]            lu_hit;
   logic [1:0]            raw_hit;
   logic [1:0]            fwd_sel [2];

   assign freeze  = dmem_req & ~dmem_ready;
   assign src[0]  = id_rs1;
   assign src[1]  = id_rs2;
   assign src_use = {id_use_rs2, id_use_rs1};

   pipe_div_seq #(
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_div (
      .clk           (clk),
      .reset         (reset),
      .div_start     (ex_div_start),
      .freeze        (freeze),
      .dstall        (dstall),
      .div_done_hold (div_done_hold),
      .div_busy      (div_busy)
   );

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_opnd
         assign lu_hit[gi] = src_use[gi]
                           & reg_hit(src[gi], ex_rd, ex_reg_write & ex_mem_read);
`ifdef PIPE_FWD_EN
         assign raw_hit[gi] = 1'b0;
         assign fwd_sel[gi] = !reset                                  ? FWD_RF  :
                              reg_hit(src[gi], mem_rd, mem_reg_write) ? FWD_MEM :
                              reg_hit(src[gi], wb_rd, wb_reg_write)   ? FWD_WB  :
                                                                        FWD_RF;
`else
         // WB is covered by the regfile write-before-read bypass.
         assign raw_hit[gi] = src_use[gi]
                            & (reg_hit(src[gi], ex_rd, ex_reg_write)
                             | reg_hit(src[gi], mem_rd, mem_reg_write));
         assign fwd_sel[gi] = FWD_RF;
`endif
      end
   endgenerate

`ifndef PIPE_FWD_EN
   logic unused_wb;
   assign unused_wb = ^{wb_rd, wb_reg_write};
`endif

   assign lu        = |lu_hit;
   assign raw       = |raw_hit;
   assign fwd_a_sel = fwd_sel[0];
   assign fwd_b_sel = fwd_sel[1];

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;

      if (freeze) begin
         // Everything holds; WB retires its write once and then sees bubbles.
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (dstall || div_done_hold) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_flush = 1'b1;
      end else if (ex_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (lu || raw) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
         pc_en       = 1'b0;
         if_id_flush = 1'b1;
      end

      if (!reset) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_en    = 1'b0;
         if_id_flush  = 1'b0;
         id_ex_flush  = 1'b0;
         ex_mem_flush = 1'b0;
         mem_wb_flush = 1'b0;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with DIV_CYCLES=4; expectations follow PIPE_FWD_EN.
module tb_pipe_hazard_ctrl;
   import pipe_pkg::*;

`ifdef PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem, mem_wb flushes}
   localparam logic [8:0] C_ZERO   = 9'b00000_0000;
   localparam logic [8:0] C_NORMAL = 9'b11111_0000;
   localparam logic [8:0] C_FREEZE = 9'b00000_0001;
   localparam logic [8:0] C_DSTALL = 9'b00011_0010;
   localparam logic [8:0] C_REDIR  = 9'b11111_1100;
   localparam logic [8:0] C_LU     = 9'b00111_0100;
   localparam logic [8:0] C_IMISS  = 9'b01111_1000;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
   logic       id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read;
   logic       mem_reg_write, wb_reg_write, ex_div_start, ex_redirect;
   logic       imem_ready, dmem_req, dmem_ready;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic       div_busy;
   logic [8:0] ctl;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

   pipe_hazard_ctrl #(.DIV_CYCLES(4), .CNT_W(3)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_use_rs1    (id_use_rs1),
      .id_use_rs2    (id_use_rs2),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .ex_div_start  (ex_div_start),
      .ex_redirect   (ex_redirect),
      .imem_ready    (imem_ready),
      .dmem_req      (dmem_req),
      .dmem_ready    (dmem_ready),
      .pc_en         (pc_en),
      .if_id_en      (if_id_en),
      .id_ex_en      (id_ex_en),
      .ex_mem_en     (ex_mem_en),
      .mem_wb_en     (mem_wb_en),
      .if_id_flush   (if_id_flush),
      .id_ex_flush   (id_ex_flush),
      .ex_mem_flush  (ex_mem_flush),
      .mem_wb_flush  (mem_wb_flush),
      .fwd_a_sel     (fwd_a_sel),
      .fwd_b_sel     (fwd_b_sel),
      .div_busy      (div_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
      end else begin
         $display("pass %s: value=%0h @%0t", tag, got, $time);
      end
   endtask

   task automatic drive_idle();
      id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
      mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
      ex_div_start = 1'b0; ex_redirect = 1'b0;
      imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load_use();
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
      id_rs1 = 5'd5; id_use_rs1 = 1'b1;
   endtask

   initial begin
      drive_idle();
      reset = 1'b0;
      mem_rd = 5'd7; mem_reg_write = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
      #3;
      check("rst_ctl", 32'(ctl), 32'(C_ZERO));
      check("rst_fwd_a", 32'(fwd_a_sel), 32'(FWD_RF));
      check("rst_busy", 32'(div_busy), 32'd0);
      tick();
      reset = 1'b1;
      drive_idle();
      #3 check("idle_ctl", 32'(ctl), 32'(C_NORMAL));

      // Load-use: one bubble, then MEM forward (or RAW stall without forwarding)
      tick(); drive_idle(); set_load_use();
      #3 check("lu_ctl", 32'(ctl), 32'(C_LU));
      tick(); drive_idle();
      mem_rd = 5'd5; mem_reg_write = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      #3 check("lu_next_ctl", 32'(ctl), 32'(FWD ? C_NORMAL : C_LU));
      check("lu_next_fwd_a", 32'(fwd_a_sel), 32'(FWD ? FWD_MEM : FWD_RF));
      tick(); drive_idle();
      wb_rd = 5'd5; wb_reg_write = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      #3 check("wb_ctl", 32'(ctl), 32'(C_NORMAL));
      check("wb_fwd_a", 32'(fwd_a_sel), 32'(FWD ? FWD_WB : FWD_RF));

      // Unused source and x0 never stall
      tick(); drive_idle();
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
      #3 check("lu_unused_ctl", 32'(ctl), 32'(C_NORMAL));
      tick(); drive_idle();
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; id_use_rs1 = 1'b1;
      #3 check("lu_x0_ctl", 32'(ctl), 32'(C_NORMAL));

      // Redirect beats load-use; imem miss; freeze beats redirect
      tick(); drive_idle(); set_load_use(); ex_redirect = 1'b1;
      #3 check("redir_lu_ctl", 32'(ctl), 32'(C_REDIR));
      tick(); drive_idle(); imem_ready = 1'b0;
      #3 check("imiss_ctl", 32'(ctl), 32'(C_IMISS));
      tick(); drive_idle(); ex_redirect = 1'b1; dmem_req = 1'b1;
      #3 check("freeze_ctl", 32'(ctl), 32'(C_FREEZE));
      tick(); drive_idle(); dmem_req = 1'b1; dmem_ready = 1'b1;
      #3 check("dmem_done_ctl", 32'(ctl), 32'(C_NORMAL));

      // Forward priority and x0
      tick(); drive_idle();
      mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
      id_rs2 = 5'd7; id_use_rs2 = 1'b1;
      #3 check("fwd_prio_b", 32'(fwd_b_sel), 32'(FWD ? FWD_MEM : FWD_RF));
      check("fwd_prio_ctl", 32'(ctl), 32'(FWD ? C_NORMAL : C_LU));
      tick(); drive_idle();
      mem_reg_write = 1'b1; wb_reg_write = 1'b1; ex_reg_write = 1'b1;
      id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
      #3 check("fwd_x0_b", 32'(fwd_b_sel), 32'(FWD_RF));
      check("fwd_x0_a", 32'(fwd_a_sel), 32'(FWD_RF));
      check("fwd_x0_ctl", 32'(ctl), 32'(C_NORMAL));

      // Divide, 4 stall cycles then release
      for (int c = 1; c <= 6; c++) begin
         tick(); drive_idle();
         ex_div_start = (c <= 5);
         #3;
         check($sformatf("div_c%0d_ctl", c), 32'(ctl), 32'(c <= 4 ? C_DSTALL : C_NORMAL));
         check($sformatf("div_c%0d_busy", c), 32'(div_busy), 32'(c >= 2 && c <= 5));
      end

      // Divide with freeze over cycles 3..8: parks in DIV_DONE, releases on 9
      for (int c = 1; c <= 10; c++) begin
         tick(); drive_idle();
         ex_div_start = (c <= 9);
         dmem_req     = (c >= 3 && c <= 8);
         #3;
         check($sformatf("divfz_c%0d_ctl", c), 32'(ctl),
               32'((c >= 3 && c <= 8) ? C_FREEZE : (c <= 2 ? C_DSTALL : C_NORMAL)));
         check($sformatf("divfz_c%0d_busy", c), 32'(div_busy), 32'(c >= 2 && c <= 5));
         if (c == 7)
            check("divfz_done_state", 32'(u_dut.u_div.state_reg), 32'(DIV_DONE));
      end

      // Reset at cnt==2 abandons the divide
      tick(); drive_idle(); ex_div_start = 1'b1;
      #3 check("rdiv_c1_ctl", 32'(ctl), 32'(C_DSTALL));
      tick();
      tick();
      #2 reset = 1'b0;
      #1 check("rdiv_async_ctl", 32'(ctl), 32'(C_ZERO));
      check("rdiv_async_busy", 32'(div_busy), 32'd0);
      check("rdiv_async_state", 32'(u_dut.u_div.state_reg), 32'(IDLE));
      tick();
      #1 check("rdiv_held_ctl", 32'(ctl), 32'(C_ZERO));
      reset = 1'b1; ex_div_start = 1'b0;
      #2 check("rdiv_rel_ctl", 32'(ctl), 32'(C_NORMAL));
      check("rdiv_rel_busy", 32'(div_busy), 32'd0);
      tick();
      #3 check("rdiv_after_state", 32'(u_dut.u_div.state_reg), 32'(IDLE));
      check("rdiv_after_busy", 32'(div_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
